// File: rtl/program_launcher_if.sv
// Request/table/core/response signal bundle between a run sequencer and the program launcher.
// The master modport is the sequencer side; the slave modport is the launcher side.
interface program_launcher_if #(
  parameter int IDXW = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [IDXW-1:0] req_prog;
  logic            tbl_wr_en;
  logic [IDXW-1:0] tbl_wr_idx;
  logic [7:0]      tbl_wr_data;
  logic            core_done;
  logic            abort;
  logic            start;
  logic [7:0]      start_addr;
  logic            busy;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [15:0]     rsp_cycles;
  logic            rsp_timeout;

  modport master (
    output req_valid, req_prog, tbl_wr_en, tbl_wr_idx, tbl_wr_data,
    output core_done, abort, rsp_ready,
    input  req_ready, start, start_addr, busy, rsp_valid, rsp_cycles, rsp_timeout
  );

  modport slave (
    input  req_valid, req_prog, tbl_wr_en, tbl_wr_idx, tbl_wr_data,
    input  core_done, abort, rsp_ready,
    output req_ready, start, start_addr, busy, rsp_valid, rsp_cycles, rsp_timeout
  );
endinterface

// File: rtl/program_launcher.sv
// Program launcher: looks up a slot's start address, holds the core at start for a fixed
// number of cycles, then times the run until done or timeout and reports the result.
module program_launcher #(
  parameter int NUM_PROGS    = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  program_launcher_if.slave    bus
);
  localparam int          IDXW        = $clog2(NUM_PROGS);
  localparam logic [15:0] LAUNCH_LAST = 16'(START_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_tbl [NUM_PROGS];
  logic [15:0] r_launch_cnt;
  logic [15:0] r_run_cnt;
  logic        r_start;
  logic [7:0]  r_start_addr;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_cycles;
  logic        r_rsp_timeout;

  logic [15:0] w_run_next;
  logic        w_timeout_hit;

  assign w_run_next    = r_run_cnt + 16'd1;
  assign w_timeout_hit = (w_run_next == TIMEOUT_W);

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.start       = r_start;
  assign bus.start_addr  = r_start_addr;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_cycles  = r_rsp_cycles;
  assign bus.rsp_timeout = r_rsp_timeout;

  // Start-address table; a request in the same cycle as a write reads the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        r_tbl[i] <= 8'h00;
      end
    end else if (bus.tbl_wr_en) begin
      r_tbl[bus.tbl_wr_idx] <= bus.tbl_wr_data;
    end
  end

  // Launch/run/response sequencer with registered core and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_launch_cnt  <= 16'd0;
      r_run_cnt     <= 16'd0;
      r_start       <= 1'b1;
      r_start_addr  <= 8'h00;
      r_rsp_valid   <= 1'b0;
      r_rsp_cycles  <= 16'd0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_start <= 1'b1;
          if (bus.req_valid) begin
            r_start_addr <= r_tbl[bus.req_prog[IDXW-1:0]];
            r_launch_cnt <= 16'd0;
            r_state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (bus.abort) begin
            r_start <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_launch_cnt == LAUNCH_LAST) begin
            r_start   <= 1'b0;
            r_run_cnt <= 16'd0;
            r_state   <= S_RUN;
          end else begin
            r_launch_cnt <= r_launch_cnt + 16'd1;
          end
        end
        S_RUN: begin
          // Done is checked before timeout so a done on the last allowed cycle is not a timeout.
          if (bus.abort) begin
            r_start <= 1'b1;
            r_state <= S_IDLE;
          end else if (bus.core_done || w_timeout_hit) begin
            r_start       <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_rsp_cycles  <= w_run_next;
            r_rsp_timeout <= ~bus.core_done;
            r_run_cnt     <= w_run_next;
            r_state       <= S_RESP;
          end else begin
            r_run_cnt <= w_run_next;
          end
        end
        S_RESP: begin
          r_start <= 1'b1;
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_start     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_launcher.sv
// Self-checking bench for program_launcher: expected responses are queued when a run is
// launched and popped when the launcher presents its result.
module tb_program_launcher;
  localparam int NUM_PROGS    = 4;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 16;

  typedef struct packed {
    logic [15:0] cycles;
    logic        timeout;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  rsp_t sb[$];

  program_launcher_if #(.IDXW(2)) ifc ();

  program_launcher #(
    .NUM_PROGS   (NUM_PROGS),
    .START_CYCLES(START_CYCLES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic [1:0] idx, input logic [7:0] data);
    step();
    ifc.tbl_wr_en   = 1'b1;
    ifc.tbl_wr_idx  = idx;
    ifc.tbl_wr_data = data;
    step();
    ifc.tbl_wr_en   = 1'b0;
  endtask

  // Launch one run and check launch timing, response contents, backpressure and release.
  task automatic do_run(input logic [1:0] prog, input logic [7:0] exp_addr, input int done_cyc,
                        input logic [15:0] exp_cyc, input logic exp_to, input int hold,
                        input logic wr_same, input logic [7:0] wr_data);
    rsp_t        e;
    int          k;
    logic [15:0] held;
    step();
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle got %0b exp 1", ifc.req_ready);
    end
    ifc.req_valid = 1'b1;
    ifc.req_prog  = prog;
    if (wr_same) begin
      ifc.tbl_wr_en   = 1'b1;
      ifc.tbl_wr_idx  = prog;
      ifc.tbl_wr_data = wr_data;
    end
    e.cycles  = exp_cyc;
    e.timeout = exp_to;
    sb.push_back(e);
    for (int c = 0; c < START_CYCLES; c++) begin
      step();
      ifc.req_valid = 1'b0;
      ifc.tbl_wr_en = 1'b0;
      checks++;
      if (ifc.start !== 1'b1 || ifc.start_addr !== exp_addr) begin
        errors++;
        $display("FAIL launch_cycle%0d start=%0b addr=%h exp start=1 addr=%h",
                 c, ifc.start, ifc.start_addr, exp_addr);
      end
    end
    step();
    checks++;
    if (ifc.start !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL run_entry start=%0b busy=%0b exp start=0 busy=1", ifc.start, ifc.busy);
    end
    k = 1;
    while (ifc.rsp_valid !== 1'b1 && k <= 64) begin
      ifc.core_done = (k == done_cyc);
      step();
      k++;
    end
    ifc.core_done = 1'b0;
    e = sb.pop_front();
    checks++;
    if (ifc.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait got rsp_valid=%0b exp 1 within 64 cycles", ifc.rsp_valid);
    end else if (ifc.rsp_cycles !== e.cycles || ifc.rsp_timeout !== e.timeout ||
                 ifc.start !== 1'b1 || ifc.start_addr !== exp_addr) begin
      errors++;
      $display("FAIL rsp_data cycles=%0d to=%0b start=%0b addr=%h exp cycles=%0d to=%0b start=1 addr=%h",
               ifc.rsp_cycles, ifc.rsp_timeout, ifc.start, ifc.start_addr,
               e.cycles, e.timeout, exp_addr);
    end
    held = e.cycles;
    for (int h = 0; h < hold; h++) begin
      step();
      checks++;
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_cycles !== held || ifc.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure%0d valid=%0b cycles=%0d req_ready=%0b exp 1 %0d 0",
                 h, ifc.rsp_valid, ifc.rsp_cycles, ifc.req_ready, held);
      end
    end
    ifc.rsp_ready = 1'b1;
    step();
    ifc.rsp_ready = 1'b0;
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release valid=%0b busy=%0b req_ready=%0b exp 0 0 1",
               ifc.rsp_valid, ifc.busy, ifc.req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (ifc.start !== 1'b1 || ifc.busy !== 1'b0 || ifc.rsp_valid !== 1'b0 ||
        ifc.start_addr !== 8'h00 || ifc.rsp_cycles !== 16'd0 || ifc.rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values start=%0b busy=%0b valid=%0b addr=%h cyc=%0d to=%0b exp 1 0 0 00 0 0",
               ifc.start, ifc.busy, ifc.rsp_valid, ifc.start_addr, ifc.rsp_cycles, ifc.rsp_timeout);
    end
    step();
    rst_n = 1'b1;
    tbl_write(2'd2, 8'h40);
    step();
    ifc.req_valid = 1'b1;
    ifc.req_prog  = 2'd2;
    step();
    ifc.req_valid = 1'b0;
    for (int i = 0; i < START_CYCLES + 2; i++) step();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.start !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_run busy=%0b start=%0b exp 1 0", ifc.busy, ifc.start);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (ifc.start !== 1'b1 || ifc.busy !== 1'b0 || ifc.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset start=%0b busy=%0b valid=%0b exp 1 0 0",
               ifc.start, ifc.busy, ifc.rsp_valid);
    end
    step();
    rst_n = 1'b1;
    // Table was cleared by reset; slot 2 must read 00 again. Done on first RUN cycle -> 1.
    do_run(2'd2, 8'h00, 1, 16'd1, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_basic_run();
    tbl_write(2'd2, 8'h40);
    do_run(2'd2, 8'h40, 5, 16'd5, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_timeout();
    do_run(2'd2, 8'h40, 0, 16'd16, 1'b1, 0, 1'b0, 8'h00);
    do_run(2'd2, 8'h40, 16, 16'd16, 1'b0, 0, 1'b0, 8'h00);
    do_run(2'd2, 8'h40, 15, 16'd15, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    tbl_write(2'd3, 8'h7c);
    do_run(2'd3, 8'h7c, 3, 16'd3, 1'b0, 10, 1'b0, 8'h00);
  endtask

  task automatic test_same_cycle_write();
    tbl_write(2'd1, 8'h10);
    do_run(2'd1, 8'h10, 2, 16'd2, 1'b0, 0, 1'b1, 8'h99);
    do_run(2'd1, 8'h99, 4, 16'd4, 1'b0, 0, 1'b0, 8'h00);
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    step();
    ifc.req_valid = 1'b1;
    ifc.req_prog  = 2'd3;
    step();
    ifc.req_valid = 1'b0;
    for (int i = 0; i < START_CYCLES + 2; i++) step();
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.start !== 1'b1 || ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle busy=%0b start=%0b req_ready=%0b exp 0 1 1",
               ifc.busy, ifc.start, ifc.req_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (ifc.rsp_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_rsp rsp_valid high %0d cycles exp 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    do_run(2'd3, 8'h7c, 1, 16'd1, 1'b0, 0, 1'b0, 8'h00);
    do_run(2'd1, 8'h99, 7, 16'd7, 1'b0, 2, 1'b0, 8'h00);
    do_run(2'd0, 8'h00, 0, 16'd16, 1'b1, 0, 1'b0, 8'h00);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    ifc.req_valid   = 1'b0;
    ifc.req_prog    = 2'd0;
    ifc.tbl_wr_en   = 1'b0;
    ifc.tbl_wr_idx  = 2'd0;
    ifc.tbl_wr_data = 8'h00;
    ifc.core_done   = 1'b0;
    ifc.abort       = 1'b0;
    ifc.rsp_ready   = 1'b0;
    test_reset();
    test_basic_run();
    test_timeout();
    test_backpressure();
    test_same_cycle_write();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
